// File: rtl/text_pkg.sv
// Shared encodings for the text scroll buffer: command opcodes, FSM states
// and the default fill character.
package text_pkg;

  localparam logic [1:0] CMD_NOP       = 2'd0;
  localparam logic [1:0] CMD_CLEAR_ALL = 2'd1;
  localparam logic [1:0] CMD_SCROLL_UP = 2'd2;
  localparam logic [1:0] CMD_CLEAR_ROW = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLR_ALL = 2'd1,
    S_CLR_ROW = 2'd2
  } state_t;

  localparam logic [6:0] FILL_CHAR = 7'h20;

endpackage

// File: rtl/text_row_map.sv
// Logical-to-physical row mapping: (logical_y + top_row) mod ROWS using a
// single compare-and-subtract. Identity mapping unless TEXTBUF_SCROLL_EN.
module text_row_map
  import text_pkg::*;
#(
  parameter int ROWS = 30,
  parameter int Y_W  = 5
) (
  input  logic [Y_W-1:0] logical_y,
  input  logic [Y_W-1:0] top_row,
  output logic [Y_W-1:0] physical_y
);

`ifdef TEXTBUF_SCROLL_EN
  logic [Y_W:0] sum_s;
  logic         wrap_s;

  assign sum_s  = {1'b0, logical_y} + {1'b0, top_row};
  assign wrap_s = (sum_s >= (Y_W+1)'(ROWS));
  assign physical_y = wrap_s ? Y_W'(sum_s - (Y_W+1)'(ROWS)) : sum_s[Y_W-1:0];
`else
  logic unused_top_s;

  assign unused_top_s = ^top_row;
  assign physical_y   = logical_y;
`endif

endmodule

// File: rtl/text_scroll_buffer.sv
// Character-cell store with valid/ready writes, clear/scroll commands and a
// registered read port mapped through the scroll offset. Hardware scrolling
// is built only when TEXTBUF_SCROLL_EN is defined.
module text_scroll_buffer
  import text_pkg::*;
#(
  parameter int                COLS      = 80,
  parameter int                ROWS      = 30,
  parameter int                CHAR_W    = 7,
  parameter int                X_W       = 7,
  parameter int                Y_W       = 5,
  parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(text_pkg::FILL_CHAR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [X_W-1:0]    wr_x,
  input  logic [Y_W-1:0]    wr_y,
  input  logic [CHAR_W-1:0] wr_data,
  output logic              wr_oob,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [Y_W-1:0]    cmd_row,
  output logic              busy,
  output logic [Y_W-1:0]    top_row,
  input  logic [X_W-1:0]    rd_x,
  input  logic [Y_W-1:0]    rd_y,
  output logic [CHAR_W-1:0] rd_data
);

  localparam int CELLS = ROWS * COLS;
  localparam int CNT_W = $clog2(CELLS);

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [Y_W-1:0]      clr_row_r, clr_row_s;
  logic [Y_W-1:0]      top_row_r, top_row_s;
  logic                wr_oob_r, wr_oob_s;
  logic [CHAR_W-1:0]   rd_data_r;
  logic [CHAR_W-1:0]   mem_r [0:CELLS-1];

  logic                mem_we_s;
  logic [CNT_W-1:0]    mem_addr_s;
  logic [CHAR_W-1:0]   mem_din_s;
  logic [Y_W-1:0]      map_wr_in_s, map_wr_out_s, map_rd_out_s;
  logic                wr_in_range_s, cmd_row_ok_s, rd_in_range_s;
  logic [CNT_W-1:0]    rd_addr_s;
  logic                unused_top_s;

  function automatic logic [CNT_W-1:0] cell_addr(input logic [Y_W-1:0] y,
                                                 input logic [X_W-1:0] x);
    return CNT_W'(y) * CNT_W'(COLS) + CNT_W'(x);
  endfunction

  // A pending command owns the write-side mapper, since it blocks the write
  assign map_wr_in_s = cmd_valid ? cmd_row : wr_y;

  text_row_map #(.ROWS(ROWS), .Y_W(Y_W)) u_map_wr (
    .logical_y  (map_wr_in_s),
    .top_row    (top_row_r),
    .physical_y (map_wr_out_s)
  );

  text_row_map #(.ROWS(ROWS), .Y_W(Y_W)) u_map_rd (
    .logical_y  (rd_y),
    .top_row    (top_row_r),
    .physical_y (map_rd_out_s)
  );

  assign wr_in_range_s = ({1'b0, wr_x} < (X_W+1)'(COLS)) && ({1'b0, wr_y} < (Y_W+1)'(ROWS));
  assign cmd_row_ok_s  = ({1'b0, cmd_row} < (Y_W+1)'(ROWS));
  assign rd_in_range_s = ({1'b0, rd_x} < (X_W+1)'(COLS)) && ({1'b0, rd_y} < (Y_W+1)'(ROWS));
  assign rd_addr_s     = rd_in_range_s ? cell_addr(map_rd_out_s, rd_x) : '0;

  // Next-state, sweep addressing and write-port selection
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    clr_row_s  = clr_row_r;
    top_row_s  = top_row_r;
    wr_oob_s   = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = cell_addr(map_wr_out_s, wr_x);
    mem_din_s  = wr_data;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            CMD_CLEAR_ALL: begin
              top_row_s = '0;
              cnt_s     = '0;
              state_s   = S_CLR_ALL;
            end
            CMD_SCROLL_UP: begin
`ifdef TEXTBUF_SCROLL_EN
              clr_row_s = top_row_r;
              top_row_s = (top_row_r == Y_W'(ROWS-1)) ? '0 : top_row_r + Y_W'(1);
              cnt_s     = '0;
              state_s   = S_CLR_ROW;
`else
              state_s   = S_IDLE;
`endif
            end
            CMD_CLEAR_ROW: begin
              if (cmd_row_ok_s) begin
                clr_row_s = map_wr_out_s;
                cnt_s     = '0;
                state_s   = S_CLR_ROW;
              end else begin
                state_s   = S_IDLE;
              end
            end
            default: state_s = S_IDLE;
          endcase
        end else if (wr_valid) begin
          mem_we_s = wr_in_range_s;
          wr_oob_s = !wr_in_range_s;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      S_CLR_ALL: begin
        mem_we_s   = 1'b1;
        mem_addr_s = cnt_r;
        mem_din_s  = FILL_CHAR;
        if (cnt_r == CNT_W'(CELLS-1)) begin
          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_CLR_ROW: begin
        mem_we_s   = 1'b1;
        mem_addr_s = cell_addr(clr_row_r, '0) + cnt_r;
        mem_din_s  = FILL_CHAR;
        if (cnt_r == CNT_W'(COLS-1)) begin
          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        cnt_s   = '0;
        state_s = S_CLR_ALL;
      end
    endcase
  end

  // Control registers; reset restarts the clear sweep from cell 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_CLR_ALL;
      cnt_r     <= '0;
      clr_row_r <= '0;
      wr_oob_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      clr_row_r <= clr_row_s;
      wr_oob_r  <= wr_oob_s;
    end
  end

`ifdef TEXTBUF_SCROLL_EN
  // Scroll offset register
  always_ff @(posedge clk) begin
    if (!reset) begin
      top_row_r <= '0;
    end else begin
      top_row_r <= top_row_s;
    end
  end
  assign unused_top_s = 1'b0;
`else
  assign top_row_r    = '0;
  assign unused_top_s = ^top_row_s;
`endif

  // Registered read; same-cell write in the same cycle yields old contents
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_r <= FILL_CHAR;
    end else begin
      rd_data_r <= rd_in_range_s ? mem_r[rd_addr_s] : FILL_CHAR;
    end
  end

  // Single-port cell memory, cleared only by the sweep
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_din_s;
    end
  end

  assign wr_ready  = (state_r == S_IDLE) && !cmd_valid;
  assign cmd_ready = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);
  assign top_row   = top_row_r;
  assign wr_oob    = wr_oob_r;
  assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_text_scroll_buffer.sv
// Self-checking bench for text_scroll_buffer: vector table plus hand-written
// sequences for sweeps, command/write collisions, scrolling and reset abort.
module tb_text_scroll_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [6:0] FILL = 7'h20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0, wr_ready, wr_oob;
  logic [6:0] wr_x = '0;
  logic [4:0] wr_y = '0;
  logic [6:0] wr_data = '0;
  logic       cmd_valid = 1'b0, cmd_ready, busy;
  logic [1:0] cmd_op = '0;
  logic [4:0] cmd_row = '0, top_row;
  logic [6:0] rd_x = '0;
  logic [4:0] rd_y = '0;
  logic [6:0] rd_data;

  int checks = 0;
  int errors = 0;
  logic [6:0] model_mem [0:CELLS-1];
  int tb_top = 0;
  logic [6:0] sb [$];

  text_scroll_buffer dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_oob(wr_oob),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .busy(busy), .top_row(top_row),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    int         x;
    int         y;
    logic [6:0] data;
    logic [6:0] exp_rd;
    bit         exp_oob;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_rd(input int x, input int y);
    if (x >= COLS || y >= ROWS) return FILL;
    return model_mem[((y + tb_top) % ROWS) * COLS + x];
  endfunction

  function automatic void model_clear_phys_row(input int prow);
    for (int c = 0; c < COLS; c++) model_mem[prow * COLS + c] = FILL;
  endfunction

  function automatic void model_clear_all();
    for (int i = 0; i < CELLS; i++) model_mem[i] = FILL;
    tb_top = 0;
  endfunction

  task automatic do_read(input int x, input int y, input logic [6:0] exp);
    rd_x = 7'(x);
    rd_y = 5'(y);
    sb.push_back(exp);
    tick();
    check("rd_data", {25'd0, rd_data}, {25'd0, sb.pop_front()});
  endtask

  task automatic do_write(input int x, input int y, input logic [6:0] d, input bit exp_oob);
    wr_valid = 1'b1;
    wr_x = 7'(x);
    wr_y = 5'(y);
    wr_data = d;
    #1;
    check("wr_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    check("wr_oob", {31'd0, wr_oob}, {31'd0, exp_oob});
    if (x < COLS && y < ROWS) model_mem[((y + tb_top) % ROWS) * COLS + x] = d;
  endtask

  task automatic do_cmd(input logic [1:0] op, input int row);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_row = 5'(row);
    #1;
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL busy_timeout: busy still %0d after %0d cycles", busy, n);
    end
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b1,  5,  2, 7'h41, 7'h00, 1'b0};
    vecs[1]  = '{1'b0,  5,  2, 7'h00, 7'h41, 1'b0};
    vecs[2]  = '{1'b1, 80,  0, 7'h55, 7'h00, 1'b1};
    vecs[3]  = '{1'b0, 79,  0, 7'h00, 7'h20, 1'b0};
    vecs[4]  = '{1'b0,  0,  0, 7'h00, 7'h20, 1'b0};
    vecs[5]  = '{1'b1, 79, 29, 7'h7a, 7'h00, 1'b0};
    vecs[6]  = '{1'b0, 79, 29, 7'h00, 7'h7a, 1'b0};
    vecs[7]  = '{1'b0, 80,  0, 7'h00, 7'h20, 1'b0};
    vecs[8]  = '{1'b0,  0, 30, 7'h00, 7'h20, 1'b0};
    vecs[9]  = '{1'b1,  0, 31, 7'h11, 7'h00, 1'b1};
    vecs[10] = '{1'b1,  0,  0, 7'h7f, 7'h00, 1'b0};
    vecs[11] = '{1'b0,  0,  0, 7'h00, 7'h7f, 1'b0};

    model_clear_all();

    // Reset state and the power-up clear sweep
    reset = 1'b0;
    repeat (3) tick();
    check("rst_top_row", {27'd0, top_row}, 32'd0);
    check("rst_rd_data", {25'd0, rd_data}, {25'd0, FILL});
    check("rst_wr_oob", {31'd0, wr_oob}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b1;
    wait_idle(n);
    check("reset_sweep_len", n, 32'd2400);
    check("idle_wr_ready", {31'd0, wr_ready}, 32'd1);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        do_read(x, y, FILL);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].x, vecs[i].y, vecs[i].data, vecs[i].exp_oob);
      else do_read(vecs[i].x, vecs[i].y, vecs[i].exp_rd);
    end
    check("oob_pulse_end", {31'd0, wr_oob}, 32'd0);

    // Same-cell read and write in one cycle returns old data
    wr_valid = 1'b1; wr_x = 7'd5; wr_y = 5'd2; wr_data = 7'h43;
    rd_x = 7'd5; rd_y = 5'd2;
    sb.push_back(exp_rd(5, 2));
    tick();
    wr_valid = 1'b0;
    check("rd_old_on_collision", {25'd0, rd_data}, {25'd0, sb.pop_front()});
    model_mem[((2 + tb_top) % ROWS) * COLS + 5] = 7'h43;
    do_read(5, 2, exp_rd(5, 2));

    // Command beats a simultaneous write; write completes after the row clear
    do_write(3, 1, 7'h51, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_row = 5'd1;
    wr_valid = 1'b1; wr_x = 7'd4; wr_y = 5'd1; wr_data = 7'h5a;
    #1;
    check("coll_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("coll_wr_ready", {31'd0, wr_ready}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    model_clear_phys_row((1 + tb_top) % ROWS);
    check("clr_row_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("clr_row_len", n, 32'd80);
    check("stalled_wr_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    model_mem[((1 + tb_top) % ROWS) * COLS + 4] = 7'h5a;
    do_read(3, 1, exp_rd(3, 1));
    do_read(4, 1, exp_rd(4, 1));

    // Out-of-range CLEAR_ROW and NOP leave the block idle
    do_cmd(2'd3, 30);
    check("clr_row_oob_busy", {31'd0, busy}, 32'd0);
    do_cmd(2'd0, 0);
    check("nop_busy", {31'd0, busy}, 32'd0);
    do_read(79, 29, exp_rd(79, 29));

    do_write(0, 0, 7'h41, 1'b0);
    do_write(0, 1, 7'h42, 1'b0);
`ifdef TEXTBUF_SCROLL_EN
    do_cmd(2'd2, 0);
    model_clear_phys_row(tb_top);
    tb_top = (tb_top + 1) % ROWS;
    check("scroll_top_row", {27'd0, top_row}, 32'd1);
    wait_idle(n);
    check("scroll_clr_len", n, 32'd80);
    do_read(0, 0, 7'h42);
    do_read(0, 29, FILL);
    for (int s = 0; s < ROWS - 1; s++) begin
      do_cmd(2'd2, 0);
      model_clear_phys_row(tb_top);
      tb_top = (tb_top + 1) % ROWS;
      wait_idle(n);
    end
    check("scroll_wrap", {27'd0, top_row}, 32'd0);
    do_write(7, 3, 7'h37, 1'b0);
    do_cmd(2'd2, 0);
    model_clear_phys_row(tb_top);
    tb_top = (tb_top + 1) % ROWS;
    wait_idle(n);
    do_read(7, 2, exp_rd(7, 2));
`else
    do_cmd(2'd2, 0);
    check("noscroll_busy", {31'd0, busy}, 32'd0);
    check("noscroll_top_row", {27'd0, top_row}, 32'd0);
    tick();
    check("noscroll_busy_later", {31'd0, busy}, 32'd0);
    do_read(0, 0, 7'h41);
    do_read(0, 1, 7'h42);
`endif

    // Full clear resets the scroll offset
    do_cmd(2'd1, 0);
    model_clear_all();
    check("clr_all_top_row", {27'd0, top_row}, 32'd0);
    wait_idle(n);
    check("clr_all_len", n, 32'd2400);
    do_read(5, 2, FILL);
    do_read(0, 1, FILL);

    // Reset mid-sweep restarts the full clear
    do_write(9, 9, 7'h39, 1'b0);
    do_cmd(2'd1, 0);
    repeat (100) tick();
    check("mid_sweep_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_clear_all();
    check("rst_abort_top_row", {27'd0, top_row}, 32'd0);
    check("rst_abort_rd_data", {25'd0, rd_data}, {25'd0, FILL});
    wait_idle(n);
    check("rst_abort_sweep_len", n, 32'd2400);
    check("rst_abort_wr_ready", {31'd0, wr_ready}, 32'd1);
    do_read(9, 9, FILL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_scroll_buffer.md
# text_scroll_buffer

Parametrised character-cell store between the text writer (terminal/UART command logic) and the VGA character renderer. It has a valid/ready write port and a command port for clear-screen, clear-row and hardware scroll-up. The scroll rotates a row-offset pointer instead of copying memory. Reads are registered, independent of writes, and map through the scroll offset so the renderer always sees logical row 0 at the top of the screen.

## Interface
- COLS, 80, columns per row
- ROWS, 30, rows per screen
- CHAR_W, 7, bits per character code
- X_W, 7, column index width (2**X_W ≥ COLS)
- Y_W, 5, row index width (2**Y_W ≥ ROWS)
- FILL_CHAR, 7'h20, code written by every clear operation and returned for out-of-range reads

- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted on a cycle where wr_valid && wr_ready
- wr_x  in  X_W  logical column
- wr_y  in  Y_W  logical row
- wr_data  in  CHAR_W  character code
- wr_oob  out  1  one-cycle pulse: the accepted write was out of range and was dropped
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted on a cycle where cmd_valid && cmd_ready
- cmd_op  in  2  0 NOP, 1 CLEAR_ALL, 2 SCROLL_UP, 3 CLEAR_ROW
- cmd_row  in  Y_W  logical row for CLEAR_ROW
- busy  out  1  a clear sweep is in progress
- top_row  out  Y_W  current physical index of logical row 0
- rd_x  in  X_W  read column
- rd_y  in  Y_W  read logical row
- rd_data  out  CHAR_W  registered read data

## Operation
- Storage is a flat array of ROWS*COLS cells. The physical row is (logical_y + top_row) mod ROWS, computed by compare-and-subtract with no divider.
- FSM states:
  - IDLE: accepts writes and commands.
  - CLR_ALL: sweeps all cells, one cell per cycle.
  - CLR_ROW: sweeps one physical row, one cell per cycle.
- cmd_ready = (state == IDLE). wr_ready = (state == IDLE) && !cmd_valid, so a command wins over a simultaneous write and the write stalls.
- Accepted write:
  - In range: the cell is updated on the accepting edge.
  - wr_x ≥ COLS or wr_y ≥ ROWS: dropped, and wr_oob is high on the following cycle.
- CLEAR_ALL: sets top_row to 0, then goes to CLR_ALL for ROWS*COLS cycles, then IDLE.
- SCROLL_UP: top_row <= (top_row + 1) mod ROWS, wrapping from ROWS-1 to 0. The old top physical row becomes the new logical bottom row. The FSM then goes to CLR_ROW on that physical row for COLS cycles.
- CLEAR_ROW:
  - cmd_row < ROWS: CLR_ROW on the mapped physical row for COLS cycles.
  - cmd_row ≥ ROWS: ignored, and the block stays in IDLE.
- NOP: accepted with no effect.
- Reads:
  - Out of range (rd_x ≥ COLS or rd_y ≥ ROWS): return FILL_CHAR.
  - Read and write to the same cell in the same cycle: the read returns the old contents.
  - During a sweep, reads return whatever the memory currently holds.
- Reset:
  - top_row = 0, rd_data = FILL_CHAR, wr_oob = 0, busy = 1, wr_ready = cmd_ready = 0.
  - The FSM enters CLR_ALL, so the memory is cleared by the sweep rather than by a reset loop.
  - Reset asserted mid-sweep aborts the sweep and restarts CLR_ALL from cell 0.

## Timing
- Write: 0-cycle accept; the new data is readable on the next cycle's read, with rd_data valid one cycle after that.
- Read latency: 1 cycle. rd_data reflects rd_x, rd_y and top_row as sampled at the previous edge.
- busy rises on the edge after a CLEAR_ALL, SCROLL_UP or valid CLEAR_ROW is accepted. It stays high for exactly ROWS*COLS or COLS cycles.
- IDLE, with wr_ready and cmd_ready high, is entered on the cycle after the last cell is written.
- The sweep counter has width $clog2(ROWS*COLS) and counts up from 0. Terminal count is N-1.
- top_row changes on the SCROLL_UP accepting edge, before the clear of the new bottom row completes.

## Configuration
- TEXTBUF_SCROLL_EN defined: top_row register and the modulo row mapping are built, and SCROLL_UP behaves as described under Operation.
- TEXTBUF_SCROLL_EN undefined:
  - top_row is tied to 0 and the mapping is the identity.
  - SCROLL_UP is accepted and treated as a NOP, with busy staying low.

## Structure
- Shared package text_pkg holds:
  - the cmd_op encoding constants (CMD_NOP, CMD_CLEAR_ALL, CMD_SCROLL_UP, CMD_CLEAR_ROW);
  - the FSM state encodings (S_IDLE, S_CLR_ALL, S_CLR_ROW);
  - FILL_CHAR default 7'h20.
- One sub-module, text_row_map: combinational (logical_y, top_row) -> physical_y. It is instantiated twice, once for the write path and once for the read path, and passes logical_y through when TEXTBUF_SCROLL_EN is undefined.

## Test plan
- Reset: hold reset low for 3 cycles, then release -> busy high for 2400 cycles; afterwards every cell reads 7'h20; wr_ready goes high on cycle 2401.
- Write (x=5, y=2, 7'h41), then read (5,2) -> rd_data = 7'h41 one cycle after the read. Write (80,0) -> wr_oob pulses and no cell changes.
- Write 'A' to row 0 and 'B' to row 1, then SCROLL_UP -> top_row = 1, busy for 80 cycles, read (0,0) = 'B', read (0,29) = 7'h20. Issue 30 scrolls -> top_row wraps back to 0.
- cmd_valid with CLEAR_ROW (row 1) and wr_valid asserted in the same cycle -> command accepted and wr_ready low; the write completes after busy falls, 80 cycles later.
- Reset pulsed 100 cycles into a CLEAR_ALL -> top_row = 0 and a fresh sweep of 2400 cycles.
- TEXTBUF_SCROLL_EN undefined, issue SCROLL_UP -> accepted, top_row stays 0, busy never rises, contents unchanged.
